spi_reg_bank: RTL and testbench

- Register-file engine between `spi_slave` and the board-control outputs.
- Consumes received bytes and transaction-begin pulses from the SPI slave, decodes a command byte, then runs auto-incrementing burst reads or writes over a 7-bit register space.
- Drives the byte returned to the SPI slave, the AeroFC bootloader-force pin, and a general-purpose output register.

---
 rtl/spi_reg_bank_if.sv | 22 ++
 rtl/spi_reg_bank.sv | 139 +++++++++++++
 tb/tb_spi_reg_bank.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_if.sv
// Byte-level link between the SPI slave front end and the register bank.
// The master side drives received bytes and begin pulses; the slave side returns tx_byte.
interface spi_reg_bank_if;
    logic       transaction_begin;
    logic       rx_byte_available;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;

    modport master (
        output transaction_begin,
        output rx_byte_available,
        output rx_byte,
        input  tx_byte
    );

    modport slave (
        input  transaction_begin,
        input  rx_byte_available,
        input  rx_byte,
        output tx_byte
    );
endinterface

// File: rtl/spi_reg_bank.sv
// Command-decoding register bank behind an SPI slave: auto-incrementing burst
// reads/writes over a 7-bit address space, driving bootloader-force and GPIO outputs.
module spi_reg_bank #(
    parameter logic [7:0] FPGA_VER = 8'hC1,
    parameter int         GPIO_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    spi_reg_bank_if.slave     spi,
    output logic              bootloader_force,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in
);
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t            state_q, state_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic              force_q, force_d;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [7:0]        scratch_q, scratch_d;
    logic [7:0]        xfer_q, xfer_d;
    logic [1:0]        rx_shift_q, rx_shift_d;
    logic [GPIO_W-1:0] gpio_meta_q, gpio_meta_d;
    logic [GPIO_W-1:0] gpio_sync_q, gpio_sync_d;

    logic       rx_edge;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] gpio_in_ext;
    logic [7:0] gpio_out_ext;

    // Zero-extend the GPIO views to a full register byte.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_gpio_ext
            if (gi < GPIO_W) begin : g_used
                assign gpio_in_ext[gi]  = gpio_sync_q[gi];
                assign gpio_out_ext[gi] = gpio_out_q[gi];
            end else begin : g_pad
                assign gpio_in_ext[gi]  = 1'b0;
                assign gpio_out_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign rx_edge          = (rx_shift_q == 2'b01);
    assign spi.tx_byte      = tx_q;
    assign bootloader_force = force_q;
    assign gpio_out         = gpio_out_q;

    // The command byte itself carries the first read address.
    always_comb begin
        rd_addr = (state_q == CMD) ? spi.rx_byte[6:0] : addr_q;
        case (rd_addr)
            7'h00:   rd_data = FPGA_VER;
            7'h01:   rd_data = {7'b0, force_q};
            7'h02:   rd_data = gpio_out_ext;
            7'h03:   rd_data = gpio_in_ext;
            7'h04:   rd_data = scratch_q;
            7'h05:   rd_data = xfer_q;
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        force_d     = force_q;
        gpio_out_d  = gpio_out_q;
        scratch_d   = scratch_q;
        xfer_d      = xfer_q;
        rx_shift_d  = {rx_shift_q[0], spi.rx_byte_available};
        gpio_meta_d = gpio_in;
        gpio_sync_d = gpio_meta_q;

        if (spi.transaction_begin) begin
            state_d = CMD;
            tx_d    = 8'h00;
        end else if (rx_edge) begin
            case (state_q)
                CMD: begin
                    if (spi.rx_byte[7]) begin
                        state_d = WDATA;
                        addr_d  = spi.rx_byte[6:0];
                    end else begin
                        state_d = RDATA;
                        addr_d  = spi.rx_byte[6:0] + 7'd1;
                        tx_d    = rd_data;
                    end
                end
                WDATA: begin
                    case (addr_q)
                        7'h01:   force_d    = spi.rx_byte[0];
                        7'h02:   gpio_out_d = spi.rx_byte[GPIO_W-1:0];
                        7'h04:   scratch_d  = spi.rx_byte;
                        default: ;
                    endcase
                    addr_d = addr_q + 7'd1;
                    xfer_d = xfer_q + 8'd1;
                    tx_d   = 8'h00;
                end
                RDATA: begin
                    tx_d   = rd_data;
                    addr_d = addr_q + 7'd1;
                    xfer_d = xfer_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            tx_q        <= '0;
            force_q     <= 1'b0;
            gpio_out_q  <= '0;
            scratch_q   <= '0;
            xfer_q      <= '0;
            rx_shift_q  <= '0;
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            force_q     <= force_d;
            gpio_out_q  <= gpio_out_d;
            scratch_q   <= scratch_d;
            xfer_q      <= xfer_d;
            rx_shift_q  <= rx_shift_d;
            gpio_meta_q <= gpio_meta_d;
            gpio_sync_q <= gpio_sync_d;
        end
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: expected tx bytes are queued as each byte is
// sent and popped once the byte has been processed.
module tb_spi_reg_bank;
    logic       clk;
    logic       reset;
    logic       bootloader_force;
    logic [7:0] gpio_out;
    logic [7:0] gpio_in;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] xfer_model = 8'h00;

    spi_reg_bank_if bus ();

    spi_reg_bank #(.FPGA_VER(8'hC1), .GPIO_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .spi              (bus.slave),
        .bootloader_force (bootloader_force),
        .gpio_out         (gpio_out),
        .gpio_in          (gpio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
        end
        $display("chk %-14s obs=%02h exp=%02h", tag, obs, exp_v);
    endtask

    task automatic do_begin();
        @(negedge clk) bus.transaction_begin = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.transaction_begin = 1'b0;
    endtask

    // Send one byte and compare tx_byte once the bank has acted on it.
    task automatic send_byte(input string tag, input logic [7:0] b, input logic [7:0] exp_tx);
        logic [7:0] e;
        exp_q.push_back(exp_tx);
        @(negedge clk);
        bus.rx_byte = b;
        bus.rx_byte_available = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) bus.rx_byte_available = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, bus.tx_byte, e);
    endtask

    task automatic send_data(input string tag, input logic [7:0] b, input logic [7:0] exp_tx);
        send_byte(tag, b, exp_tx);
        xfer_model++;
    endtask

    initial begin
        bus.transaction_begin = 1'b0;
        bus.rx_byte_available = 1'b0;
        bus.rx_byte = 8'h00;
        gpio_in = 8'h5A;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("rst_tx", bus.tx_byte, 8'h00);
        check("rst_force", {7'b0, bootloader_force}, 8'h00);
        check("rst_gpio", gpio_out, 8'h00);

        // Bytes before any begin are ignored.
        send_byte("idle_b0", 8'h82, 8'h00);
        send_byte("idle_b1", 8'h55, 8'h00);
        check("idle_gpio", gpio_out, 8'h00);

        // Read VERSION then FORCE_BT, then XFER_COUNT.
        do_begin();
        check("begin_tx", bus.tx_byte, 8'h00);
        send_byte("rd_ver", 8'h00, 8'hC1);
        send_data("rd_force", 8'hAA, 8'h00);
        do_begin();
        check("begin_clr", bus.tx_byte, 8'h00);
        send_byte("rd_xfer1", 8'h05, xfer_model);

        // Bootloader force set then cleared via bit 0 only.
        do_begin();
        send_byte("w_cmd81", 8'h81, 8'h00);
        send_data("w_force1", 8'h01, 8'h00);
        check("force_set", {7'b0, bootloader_force}, 8'h01);
        do_begin();
        send_byte("w_cmd81b", 8'h81, 8'h00);
        send_data("w_forceFE", 8'hFE, 8'h00);
        check("force_clr", {7'b0, bootloader_force}, 8'h00);

        // Write burst across GPIO_OUT, GPIO_IN (dropped), SCRATCH.
        do_begin();
        send_byte("w_cmd82", 8'h82, 8'h00);
        send_data("w_gpio", 8'hA5, 8'h00);
        send_data("w_gpin", 8'h3C, 8'h00);
        send_data("w_scr", 8'h77, 8'h00);
        check("gpio_out", gpio_out, 8'hA5);

        // Read burst 0x02..0x06; XFER_COUNT returns its pre-update value.
        do_begin();
        send_byte("rd_gpio", 8'h02, 8'hA5);
        send_data("rd_gpin", 8'h00, 8'h5A);
        send_data("rd_scr", 8'h00, 8'h77);
        send_data("rd_xfer", 8'h00, xfer_model);
        send_data("rd_rsv6", 8'h00, 8'h00);

        // Write at 0x7F wraps to 0x00; both writes are dropped.
        do_begin();
        send_byte("w_cmdFF", 8'hFF, 8'h00);
        send_data("w_7f", 8'h11, 8'h00);
        send_data("w_00", 8'h22, 8'h00);
        do_begin();
        send_byte("rd_ver2", 8'h00, 8'hC1);
        do_begin();
        send_byte("rd_7f", 8'h7F, 8'h00);
        send_data("rd_wrap", 8'h00, 8'hC1);

        // begin coinciding with rx_edge: byte discarded, bank waits for a command.
        do_begin();
        send_byte("rd_scr2", 8'h04, 8'h77);
        @(negedge clk);
        bus.rx_byte = 8'h99;
        bus.rx_byte_available = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.transaction_begin = 1'b1;
        @(posedge clk);
        @(negedge clk) bus.transaction_begin = 1'b0;
        check("coll_tx", bus.tx_byte, 8'h00);
        @(negedge clk) bus.rx_byte_available = 1'b0;
        repeat (2) @(posedge clk);
        send_byte("coll_cmd", 8'h84, 8'h00);
        send_data("coll_wr", 8'h3C, 8'h00);
        do_begin();
        send_byte("rd_scr3", 8'h04, 8'h3C);
        do_begin();
        send_byte("rd_xfer2", 8'h05, xfer_model);

        // Reset between bytes of a write burst.
        do_begin();
        send_byte("w_cmd82b", 8'h82, 8'h00);
        send_data("w_gpio2", 8'h11, 8'h00);
        check("gpio_pre", gpio_out, 8'h11);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        xfer_model = 8'h00;
        check("rst_gpio2", gpio_out, 8'h00);
        send_byte("post_rst", 8'h22, 8'h00);
        check("post_gpio", gpio_out, 8'h00);
        do_begin();
        send_byte("rd_xfer0", 8'h05, xfer_model);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
